// File: rtl/hazard_tnew_ctrl.sv
// Producer side of the forwarding network.
// Carries each instruction's write info (A3, WE, Tnew) down the E/M/W stages.
// Compares the D-stage Tuse values against in-flight Tnew and raises a stall.
// Also tracks the multiply/divide unit's busy window and holds back D-stage
// instructions that depend on it.
module hazard_tnew_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic       D_use_rs,
    input  logic       D_use_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_A3,
    input  logic       D_WE,
    input  logic [1:0] D_Tnew,
    input  logic       D_md_start,
    input  logic       D_md_div,
    input  logic       D_md_use,
    output logic       stall,
    output logic [4:0] E_A3,
    output logic [4:0] M_A3,
    output logic [4:0] W_A3,
    output logic       E_WE,
    output logic       M_WE,
    output logic       W_WE,
    output logic [1:0] E_Tnew,
    output logic [1:0] M_Tnew,
    output logic       md_busy
);

    localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    logic          E_md_q;
    logic          E_div_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    e_tnew_dec;
    logic          stall_rs, stall_rt, stall_md;

    // Tnew counts down one per stage but never wraps below zero
    assign e_tnew_dec = (E_Tnew == 2'd0) ? 2'd0 : E_Tnew - 2'd1;

    // A source register stalls only if a producer in E or M still needs more
    // cycles than the consumer can wait; $0 is never a real dependency
    assign stall_rs = D_use_rs && (D_rs != 5'd0) &&
                      ((E_WE && (E_A3 == D_rs) && (E_Tnew > D_Tuse_rs)) ||
                       (M_WE && (M_A3 == D_rs) && (M_Tnew > D_Tuse_rs)));
    assign stall_rt = D_use_rt && (D_rt != 5'd0) &&
                      ((E_WE && (E_A3 == D_rt) && (E_Tnew > D_Tuse_rt)) ||
                       (M_WE && (M_A3 == D_rt) && (M_Tnew > D_Tuse_rt)));

    // The op sitting in E has not loaded the counter yet, so it counts as busy too
    assign md_busy  = (cnt_q != '0);
    assign stall_md = D_md_use && (E_md_q || md_busy);
    assign stall    = stall_rs || stall_rt || stall_md;

    // MD busy counter: a new op in E reloads it (back-to-back ops restart the window)
    always_comb begin
        cnt_d = cnt_q;
        if (E_md_q)
            cnt_d = E_div_q ? CW'(DIV_LAT) : CW'(MULT_LAT);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    // Pipeline registers: a stall injects an all-zero bubble into E
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            E_A3    <= 5'd0;
            E_WE    <= 1'b0;
            E_Tnew  <= 2'd0;
            E_md_q  <= 1'b0;
            E_div_q <= 1'b0;
            M_A3    <= 5'd0;
            M_WE    <= 1'b0;
            M_Tnew  <= 2'd0;
            W_A3    <= 5'd0;
            W_WE    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (stall) begin
                E_A3    <= 5'd0;
                E_WE    <= 1'b0;
                E_Tnew  <= 2'd0;
                E_md_q  <= 1'b0;
                E_div_q <= 1'b0;
            end else begin
                E_A3    <= D_A3;
                E_WE    <= D_WE && (D_A3 != 5'd0);
                E_Tnew  <= D_Tnew;
                E_md_q  <= D_md_start;
                E_div_q <= D_md_start && D_md_div;
            end
            M_A3   <= E_A3;
            M_WE   <= E_WE;
            M_Tnew <= e_tnew_dec;
            W_A3   <= M_A3;
            W_WE   <= M_WE;
            cnt_q  <= cnt_d;
        end
    end

endmodule
